// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state type and width helpers
// for the execute stage and its multiplier.
package exec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam int WORD_W_DEF = 32;
    localparam int SHAMT_W    = $clog2(WORD_W_DEF);

    function automatic int shamt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/exec_unit_seq_mul.sv
// Iterative unsigned shift-add multiplier, one bit per cycle.
// o_prod is the next-state product, complete while o_done is high.
module seq_mul #(
    parameter int WORD_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [WORD_W-1:0]     i_a,
    input  logic [WORD_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*WORD_W-1:0]   o_prod
);

    localparam int CNT_W = $clog2(WORD_W) + 1;

    logic [2*WORD_W-1:0] prod_q;
    logic [WORD_W-1:0]   mcand_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic [WORD_W:0]     sum;
    logic [2*WORD_W-1:0] prod_nxt;

    // Multiplier sits in the low half and shifts out as the
    // partial product grows into the high half.
    always_comb begin
        sum = {1'b0, prod_q[2*WORD_W-1:WORD_W]};
        if (prod_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        prod_nxt = {sum, prod_q[WORD_W-1:1]};
    end

    assign o_done = busy_q && (cnt_q == CNT_W'(WORD_W - 1));
    assign o_prod = prod_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (i_start && !busy_q) begin
            prod_q  <= {{WORD_W{1'b0}}, i_b};
            mcand_q <= i_a;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q + 1'b1;
            if (o_done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU, iterative MUL and registered
// write-back port, with valid/ready stall while a MUL is running.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_B = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic [WORD_W-1:0] i_rs1_data,
    input  logic [WORD_W-1:0] i_rs2_data,
    input  logic [ADDR_B-1:0] i_rd_addr,
    output logic              o_wen,
    output logic [ADDR_B-1:0] o_write_addr,
    output logic [WORD_W-1:0] o_write_data,
    output logic              o_overflow,
    output logic              o_illegal
);

    localparam int SHW = shamt_w(WORD_W);
    localparam int MSB = WORD_W - 1;

    state_t              state;
    logic [ADDR_B-1:0]   mul_rd_q;
    logic                mul_start;
    logic                mul_done;
    logic [2*WORD_W-1:0] mul_prod;
    logic [WORD_W-1:0]   sum;
    logic [WORD_W-1:0]   diff;
    logic [WORD_W-1:0]   alu_res;
    logic                alu_ovf;

    assign sum  = i_rs1_data + i_rs2_data;
    assign diff = i_rs1_data - i_rs2_data;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (i_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (i_rs1_data[MSB] == i_rs2_data[MSB])
                        && (sum[MSB] != i_rs1_data[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (i_rs1_data[MSB] != i_rs2_data[MSB])
                        && (diff[MSB] != i_rs1_data[MSB]);
            end
            OP_AND: alu_res = i_rs1_data & i_rs2_data;
            OP_OR:  alu_res = i_rs1_data | i_rs2_data;
            OP_SLT: alu_res = WORD_W'($signed(i_rs1_data)
                                    < $signed(i_rs2_data));
            OP_SLL: alu_res = i_rs1_data << i_rs2_data[SHW-1:0];
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    assign mul_start = i_valid && (state == S_IDLE) && (i_op == OP_MUL);

    seq_mul #(
        .WORD_W (WORD_W)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (mul_start),
        .i_a     (i_rs1_data),
        .i_b     (i_rs2_data),
        .o_done  (mul_done),
        .o_prod  (mul_prod)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            o_ready      <= 1'b1;
            mul_rd_q     <= '0;
            o_wen        <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
            o_overflow   <= 1'b0;
            o_illegal    <= 1'b0;
        end else begin
            o_wen     <= 1'b0;
            o_illegal <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_op == OP_MUL) begin
                            state    <= S_BUSY;
                            o_ready  <= 1'b0;
                            mul_rd_q <= i_rd_addr;
                        end else if (i_op == OP_RSV) begin
                            o_illegal <= 1'b1;
                        end else begin
                            o_wen        <= (i_rd_addr != '0);
                            o_write_addr <= i_rd_addr;
                            o_write_data <= alu_res;
                            o_overflow   <= alu_ovf;
                        end
                    end
                end
                S_BUSY: begin
                    if (mul_done) begin
                        state        <= S_IDLE;
                        o_ready      <= 1'b1;
                        o_wen        <= (mul_rd_q != '0);
                        o_write_addr <= mul_rd_q;
                        o_write_data <= mul_prod[WORD_W-1:0];
                        o_overflow   <= |mul_prod[2*WORD_W-1:WORD_W];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed vector bench for exec_unit: ALU table, MUL sequences,
// reserved opcode, x0 destination and reset during a multiply.
module tb_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ovf;
    logic        ill;

    int total = 0;
    int bad   = 0;

    exec_unit #(
        .WORD_W (32),
        .ADDR_B (5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_op         (op),
        .i_rs1_data   (a),
        .i_rs2_data   (b),
        .i_rd_addr    (rd),
        .o_wen        (wen),
        .o_write_addr (waddr),
        .o_write_data (wdata),
        .o_overflow   (ovf),
        .o_illegal    (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        valid = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        rd    = v.rd;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d wen", idx), 64'(wen), 64'(v.wen));
        chk($sformatf("v%0d illegal", idx), 64'(ill), 64'(v.ill));
        chk($sformatf("v%0d ready", idx), 64'(ready), 64'd1);
        if (v.wen) begin
            chk($sformatf("v%0d addr", idx), 64'(waddr), 64'(v.rd));
            chk($sformatf("v%0d data", idx), 64'(wdata), 64'(v.data));
            chk($sformatf("v%0d ovf", idx), 64'(ovf), 64'(v.ovf));
        end
    endtask

    task automatic do_mul(input logic [31:0] ma, input logic [31:0] mb,
                          input logic [4:0] mrd, input logic [31:0] exp_d,
                          input logic exp_o);
        int cyc;
        int rdy_hi;
        int wen_cnt;
        @(negedge clk);
        valid = 1'b1;
        op    = 3'b110;
        a     = ma;
        b     = mb;
        rd    = mrd;
        @(posedge clk);
        cyc    = 0;
        rdy_hi = 0;
        while (cyc < 100) begin
            #1;
            if (wen) break;
            if (ready) rdy_hi++;
            @(posedge clk);
            cyc++;
        end
        // valid stays high the whole time; drop it before the next edge
        valid = 1'b0;
        chk("mul latency", 64'(cyc), 64'd32);
        chk("mul ready low while busy", 64'(rdy_hi), 64'd0);
        chk("mul ready with wen", 64'(ready), 64'd1);
        chk("mul addr", 64'(waddr), 64'(mrd));
        chk("mul data", 64'(wdata), 64'(exp_d));
        chk("mul ovf", 64'(ovf), 64'(exp_o));
        wen_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (wen) wen_cnt++;
        end
        chk("mul single write", 64'(wen_cnt), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   wen_cnt;

        vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h1, 5'd3,
                     1'b1, 32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 32'd5, 32'd7, 5'd4,
                     1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd5,
                     1'b1, 32'hF000F000, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'h1, 5'd6,
                     1'b1, 32'h1, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 32'h1, 32'h25, 5'd8,
                     1'b1, 32'h20, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'h12340000, 32'h5678, 5'd9,
                     1'b1, 32'h12345678, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 32'd1, 32'd1, 5'd0,
                     1'b0, 32'd2, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 32'd3, 32'd4, 5'd10,
                     1'b0, 32'd0, 1'b0, 1'b1};
        vecs[8]  = '{3'b001, 32'h80000000, 32'h1, 5'd11,
                     1'b1, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[9]  = '{3'b100, 32'h1, 32'hFFFFFFFF, 5'd12,
                     1'b1, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'h1, 5'd31,
                     1'b1, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{3'b101, 32'h80000001, 32'h1F, 5'd1,
                     1'b1, 32'h80000000, 1'b0, 1'b0};

        rst_n = 1'b0;
        valid = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wen", 64'(wen), 64'd0);
        chk("rst addr", 64'(waddr), 64'd0);
        chk("rst data", 64'(wdata), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        chk("rst illegal", 64'(ill), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after rst", 64'(ready), 64'd1);

        // back-to-back single-cycle ops
        for (int i = 0; i < 12; i++) begin
            apply_vec(vecs[i], i);
        end
        @(negedge clk);
        valid = 1'b0;

        do_mul(32'h10000, 32'h10000, 5'd7, 32'h0, 1'b1);
        do_mul(32'd1234, 32'd5678, 5'd14, 32'd7006652, 1'b0);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h1, 1'b1);

        // reset mid-multiply
        @(negedge clk);
        valid = 1'b1;
        op    = 3'b110;
        a     = 32'd1234;
        b     = 32'd5678;
        rd    = 5'd12;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("pre-rst busy", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid rst wen", 64'(wen), 64'd0);
        chk("mid rst addr", 64'(waddr), 64'd0);
        chk("mid rst data", 64'(wdata), 64'd0);
        chk("mid rst ovf", 64'(ovf), 64'd0);
        chk("mid rst illegal", 64'(ill), 64'd0);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wen_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (wen) wen_cnt++;
        end
        chk("no write after rst", 64'(wen_cnt), 64'd0);
        chk("ready after mid rst", 64'(ready), 64'd1);

        v = '{3'b000, 32'd2, 32'd3, 5'd13, 1'b1, 32'd5, 1'b0, 1'b0};
        apply_vec(v, 100);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wen one-cycle", 64'(wen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the team's simple CPU datapath. Consumes the two operand words read from the register file plus decoded opcode and destination address. Computes the result, single-cycle for ALU ops and iterative for multiply. Produces the write-back triple (`o_wen`, `o_write_addr`, `o_write_data`) that drives the register file's write port directly. A valid/ready handshake stalls the upstream decoder while a multiply is in flight.

## Interface
- `WORD_W`, default 32: operand/result width.
- `ADDR_B`, default 5: register address width.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: reset, asynchronous, active-low. Clock is `i_clk`.
- `i_valid`, input, 1: operation presented this cycle.
- `o_ready`, output, 1: unit can accept; a transfer occurs when `i_valid & o_ready` at the rising edge.
- `i_op`, input, 3: opcode, defined under Operation.
- `i_rs1_data`, input, `WORD_W`: operand A.
- `i_rs2_data`, input, `WORD_W`: operand B.
- `i_rd_addr`, input, `ADDR_B`: destination register.
- `o_wen`, output, 1: one-cycle write-back pulse.
- `o_write_addr`, output, `ADDR_B`: write-back address.
- `o_write_data`, output, `WORD_W`: write-back data.
- `o_overflow`, output, 1: overflow flag, qualified by `o_wen`.
- `o_illegal`, output, 1: one-cycle pulse for an accepted reserved opcode.

## Operation
- Opcodes:
  - 000 ADD: wraps mod 2^WORD_W; overflow = signed overflow.
  - 001 SUB: A−B; overflow = signed overflow.
  - 010 AND.
  - 011 OR.
  - 100 SLT: 1 if signed A<B, else 0.
  - 101 SLL: A << B[$clog2(WORD_W)-1:0]; upper bits of B are ignored.
  - 110 MUL: unsigned; result = low WORD_W bits of A*B; overflow = high half nonzero.
  - 111: reserved. No write; `o_illegal` pulses.
- `o_overflow` is 0 for AND/OR/SLT/SLL.
- Destination x0: if `i_rd_addr` == 0, result is computed but `o_wen` stays 0. `o_overflow` is still reported, and MUL still occupies the unit.
- FSM states:
  - IDLE: `o_ready`=1. Accepting MUL latches operands and rd, then goes to BUSY. Any other accepted op stays IDLE.
  - BUSY: `o_ready`=0. Runs one shift-add iteration per cycle for WORD_W cycles. On the last iteration edge, registers the result with `o_wen` and returns to IDLE.
- `i_valid` while `o_ready`=0 is ignored; upstream must hold its request.
- Reset, including mid-multiply: state IDLE, partial product discarded, no write issued.
- Reset values: `o_wen`, `o_write_addr`, `o_write_data`, `o_overflow`, `o_illegal` all 0. `o_ready` is 1 once reset deasserts.

## Timing
- All outputs are registered.
- Non-MUL latency is 1. An op accepted at edge k has `o_wen`/data valid in the cycle after edge k. Back-to-back issue gives one write per cycle.
- MUL latency is WORD_W. For a MUL accepted at edge k, `o_wen` is visible after edge k+WORD_W. `o_ready` is low from edge k to edge k+WORD_W, then rises in the same cycle `o_wen` is high. A new op may be accepted at edge k+WORD_W+1.
- `o_write_addr`, `o_write_data` and `o_overflow` hold their last value when `o_wen`=0. The verifier checks them only when `o_wen`=1.
- Register-file read-after-write: this unit does no forwarding; the hazard is upstream's responsibility.

## Structure
- Package `exec_pkg`:
  - opcode localparams (`OP_ADD` … `OP_MUL`, `OP_RSV`);
  - FSM state type (`S_IDLE`, `S_BUSY`);
  - `SHAMT_W` = $clog2(WORD_W).
- Sub-module `seq_mul`: iterative unsigned shift-add multiplier with start/done.
  - Has a 2·WORD_W product register and an iteration counter of $clog2(WORD_W)+1 bits.
  - `exec_unit` holds the FSM, the combinational ALU and the write-back registers.

## Test plan
- ADD 0x7FFFFFFF+1 to rd=3 → next cycle `o_wen`=1, addr 3, data 0x80000000, `o_overflow`=1. SUB 5−7 → 0xFFFFFFFE, overflow 0.
- Back-to-back AND(0xF0F0F0F0, 0xFF00FF00)=0xF000F000, SLT(-1, 1)=1, SLL(1, 0x25)=0x20 on consecutive cycles → three consecutive `o_wen` pulses, `o_ready` constantly 1.
- MUL 0x10000×0x10000 to rd=7 → `o_ready` low 32 cycles, then `o_wen` with data 0, `o_overflow`=1. MUL 1234×5678 → 7006652, overflow 0. `i_valid` held during BUSY is not accepted twice.
- rd=0: ADD 1+1 → `o_wen` stays 0. Opcode 111 → `o_illegal` pulse, no write.
- Assert reset at iteration 10 of a MUL → all outputs 0 immediately, no `o_wen` afterward, `o_ready`=1 after release. The next ADD completes normally.
